// File: rtl/reg_file_2r1w_sb.sv
// Two-read / one-write register file with registered reads, optional write-to-read
// bypass, optional hard-wired zero register and a per-register busy scoreboard.
module reg_file_2r1w_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  input  logic                 rd_en_a_i,
  input  logic [ADDR_W-1:0]    rd_addr_a_i,
  output logic [DATA_W-1:0]    rd_data_a_o,
  output logic                 rd_valid_a_o,
  input  logic                 rd_en_b_i,
  input  logic [ADDR_W-1:0]    rd_addr_b_i,
  output logic [DATA_W-1:0]    rd_data_b_o,
  output logic                 rd_valid_b_o,
  input  logic                 rsv_en_i,
  input  logic [ADDR_W-1:0]    rsv_addr_i,
  output logic                 busy_a_o,
  output logic                 busy_b_o,
  output logic [2**ADDR_W-1:0] busy_vec_o
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0]   rd_data_b_q, rd_data_b_d;
  logic                rd_valid_a_q, rd_valid_b_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wr_allowed;
  logic                fwd_a, fwd_b;

  assign wr_allowed = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));
  assign fwd_a      = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_a_i);
  assign fwd_b      = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_b_i);

  // Zero-register override is applied last so it also beats the bypass path.
  always_comb begin
    rd_data_a_d = fwd_a ? wr_data_i : mem_q[rd_addr_a_i];
    rd_data_b_d = fwd_b ? wr_data_i : mem_q[rd_addr_b_i];
    if ((ZERO_REG != 0) && (rd_addr_a_i == '0)) rd_data_a_d = '0;
    if ((ZERO_REG != 0) && (rd_addr_b_i == '0)) rd_data_b_d = '0;
  end

  // Release first, then reserve: a new producer issued on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
    if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      busy_q       <= '0;
    end else begin
      if (wr_allowed) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_a_i) rd_data_a_q <= rd_data_a_d;
      if (rd_en_b_i) rd_data_b_q <= rd_data_b_d;
      rd_valid_a_q <= rd_en_a_i;
      rd_valid_b_q <= rd_en_b_i;
      busy_q       <= busy_d;
    end
  end

  assign rd_data_a_o  = rd_data_a_q;
  assign rd_data_b_o  = rd_data_b_q;
  assign rd_valid_a_o = rd_valid_a_q;
  assign rd_valid_b_o = rd_valid_b_q;
  assign busy_vec_o   = busy_q;
  assign busy_a_o     = busy_q[rd_addr_a_i] && !fwd_a;
  assign busy_b_o     = busy_q[rd_addr_b_i] && !fwd_b;

endmodule

// File: tb/tb_reg_file_2r1w_sb.sv
// Bench for reg_file_2r1w_sb: a default instance (bypass, no zero reg) and a wide
// instance (ADDR_W=5, DATA_W=64, zero reg, no bypass) checked against array models.
module tb_reg_file_2r1w_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   testsRun = 0;
  int   testsFailed = 0;
  logic checking = 1'b0;

  // instance 1 signals
  logic        wrEn1, rdEnA1, rdEnB1, rsvEn1;
  logic [3:0]  wrAddr1, rdAddrA1, rdAddrB1, rsvAddr1;
  logic [31:0] wrData1, rdDataA1, rdDataB1;
  logic        rdValidA1, rdValidB1, busyA1, busyB1;
  logic [15:0] busyVec1;

  // instance 2 signals
  logic        wrEn2, rdEnA2, rdEnB2, rsvEn2;
  logic [4:0]  wrAddr2, rdAddrA2, rdAddrB2, rsvAddr2;
  logic [63:0] wrData2, rdDataA2, rdDataB2;
  logic        rdValidA2, rdValidB2, busyA2, busyB2;
  logic [31:0] busyVec2;

  reg_file_2r1w_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wrEn1), .wr_addr_i(wrAddr1), .wr_data_i(wrData1),
    .rd_en_a_i(rdEnA1), .rd_addr_a_i(rdAddrA1), .rd_data_a_o(rdDataA1), .rd_valid_a_o(rdValidA1),
    .rd_en_b_i(rdEnB1), .rd_addr_b_i(rdAddrB1), .rd_data_b_o(rdDataB1), .rd_valid_b_o(rdValidB1),
    .rsv_en_i(rsvEn1), .rsv_addr_i(rsvAddr1),
    .busy_a_o(busyA1), .busy_b_o(busyB1), .busy_vec_o(busyVec1)
  );

  reg_file_2r1w_sb #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wrEn2), .wr_addr_i(wrAddr2), .wr_data_i(wrData2),
    .rd_en_a_i(rdEnA2), .rd_addr_a_i(rdAddrA2), .rd_data_a_o(rdDataA2), .rd_valid_a_o(rdValidA2),
    .rd_en_b_i(rdEnB2), .rd_addr_b_i(rdAddrB2), .rd_data_b_o(rdDataB2), .rd_valid_b_o(rdValidB2),
    .rsv_en_i(rsvEn2), .rsv_addr_i(rsvAddr2),
    .busy_a_o(busyA2), .busy_b_o(busyB2), .busy_vec_o(busyVec2)
  );

  // An unknown write address while writing is a stimulus error, not a design state.
  always @(posedge clk) begin
    if (!rst && wrEn1) assert (!$isunknown(wrAddr1)) else $error("[TB] X on wrAddr1");
    if (!rst && wrEn2) assert (!$isunknown(wrAddr2)) else $error("[TB] X on wrAddr2");
  end

  // Behavioural models: plain arrays plus a busy bit per register.
  logic [31:0] m1 [16];
  logic [15:0] b1;
  logic [31:0] eA1, eB1;
  logic        vA1, vB1;
  logic [63:0] m2 [32];
  logic [31:0] b2;
  logic [63:0] eA2, eB2;
  logic        vA2, vB2;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m1[i] = '0;
      for (int i = 0; i < 32; i++) m2[i] = '0;
      b1 = '0; b2 = '0;
      eA1 = '0; eB1 = '0; vA1 = 0; vB1 = 0;
      eA2 = '0; eB2 = '0; vA2 = 0; vB2 = 0;
    end else begin
      // instance 1: a same-cycle write is seen by the read
      if (rdEnA1) eA1 = (wrEn1 && wrAddr1 == rdAddrA1) ? wrData1 : m1[rdAddrA1];
      if (rdEnB1) eB1 = (wrEn1 && wrAddr1 == rdAddrB1) ? wrData1 : m1[rdAddrB1];
      vA1 = rdEnA1; vB1 = rdEnB1;
      if (wrEn1) begin m1[wrAddr1] = wrData1; b1[wrAddr1] = 1'b0; end
      if (rsvEn1) b1[rsvAddr1] = 1'b1;
      // instance 2: old contents are read, register 0 is always zero and never busy
      if (rdEnA2) eA2 = (rdAddrA2 == 0) ? 64'd0 : m2[rdAddrA2];
      if (rdEnB2) eB2 = (rdAddrB2 == 0) ? 64'd0 : m2[rdAddrB2];
      vA2 = rdEnA2; vB2 = rdEnB2;
      if (wrEn2) begin
        if (wrAddr2 != 0) m2[wrAddr2] = wrData2;
        b2[wrAddr2] = 1'b0;
      end
      if (rsvEn2 && rsvAddr2 != 0) b2[rsvAddr2] = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cmp rdDataA1", rdDataA1, eA1);
      checkOutput("cmp rdDataB1", rdDataB1, eB1);
      checkOutput("cmp rdValidA1", rdValidA1, vA1);
      checkOutput("cmp rdValidB1", rdValidB1, vB1);
      checkOutput("cmp busyVec1", busyVec1, b1);
      checkOutput("cmp busyA1", busyA1, b1[rdAddrA1] && !(wrEn1 && wrAddr1 == rdAddrA1));
      checkOutput("cmp busyB1", busyB1, b1[rdAddrB1] && !(wrEn1 && wrAddr1 == rdAddrB1));
      checkOutput("cmp rdDataA2", rdDataA2, eA2);
      checkOutput("cmp rdDataB2", rdDataB2, eB2);
      checkOutput("cmp rdValidA2", rdValidA2, vA2);
      checkOutput("cmp rdValidB2", rdValidB2, vB2);
      checkOutput("cmp busyVec2", busyVec2, b2);
      checkOutput("cmp busyA2", busyA2, b2[rdAddrA2]);
      checkOutput("cmp busyB2", busyB2, b2[rdAddrB2]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives both instances with the same transaction; instance 2 gets {~data, data}.
  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic rea, input logic [3:0] ra,
                               input logic reb, input logic [3:0] rb,
                               input logic rs, input logic [3:0] rsa);
    wrEn1 = we;  wrAddr1 = wa;  wrData1 = wd;
    rdEnA1 = rea; rdAddrA1 = ra; rdEnB1 = reb; rdAddrB1 = rb;
    rsvEn1 = rs; rsvAddr1 = rsa;
    wrEn2 = we;  wrAddr2 = {1'b0, wa}; wrData2 = {~wd, wd};
    rdEnA2 = rea; rdAddrA2 = {1'b0, ra}; rdEnB2 = reb; rdAddrB2 = {1'b0, rb};
    rsvEn2 = rs; rsvAddr2 = {1'b0, rsa};
  endtask

  function automatic logic [63:0] sweepVal(input int i);
    logic [63:0] pat = 64'hA5A5_5A5A_0F0F_F0F0;
    return (i == 0) ? 64'd0 : (64'(i) ^ pat);
  endfunction

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    checking = 1'b1;

    // reset after a write/reserve pattern
    applyStimulus(1, 3, 32'hCAFE_0003, 0, 0, 0, 0, 1, 4);
    tick();
    applyStimulus(1, 6, 32'hCAFE_0006, 1, 3, 0, 0, 1, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset busyVec1", busyVec1, 16'h0);
    checkOutput("reset rdValidA1", rdValidA1, 1'b0);
    checkOutput("reset rdValidB1", rdValidB1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 1, 4'(i), 1, 4'(15 - i), 0, 0);
      tick();
      checkOutput("reset rdDataA1", rdDataA1, 32'h0);
      checkOutput("reset rdDataB1", rdDataB1, 32'h0);
    end

    // write then read
    applyStimulus(1, 0, 32'h0628_0060, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 9, 32'h0608_0020, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 1, 0, 1, 9, 0, 0); tick();
    checkOutput("wr/rd A1", rdDataA1, 32'h0628_0060);
    checkOutput("wr/rd B1", rdDataB1, 32'h0608_0020);
    checkOutput("wr/rd validA1", rdValidA1, 1'b1);
    checkOutput("wr/rd validB1", rdValidB1, 1'b1);
    checkOutput("wr/rd A2 zero reg", rdDataA2, 64'h0);
    checkOutput("wr/rd B2", rdDataB2, 64'hF9F7_FFDF_0608_0020);

    // bypass on the same-cycle write
    applyStimulus(1, 5, 32'h1111_1111, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 5, 32'hDEAD_BEEF, 1, 5, 1, 5, 0, 0); tick();
    checkOutput("bypass A1", rdDataA1, 32'hDEAD_BEEF);
    checkOutput("bypass B1", rdDataB1, 32'hDEAD_BEEF);
    checkOutput("no bypass A2", rdDataA2, 64'hEEEE_EEEE_1111_1111);
    applyStimulus(0, 0, 0, 1, 5, 0, 0, 0, 0); tick();
    checkOutput("reread A1", rdDataA1, 32'hDEAD_BEEF);
    checkOutput("reread A2", rdDataA2, 64'h2152_4110_DEAD_BEEF);

    // scoreboard
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7); tick();
    checkOutput("rsv busyVec1[7]", busyVec1[7], 1'b1);
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 0, 0); #1;
    checkOutput("busyA1 pending", busyA1, 1'b1);
    applyStimulus(1, 7, 32'h7777_7777, 1, 7, 0, 0, 0, 0); #1;
    checkOutput("busyA1 writeback", busyA1, 1'b0);
    checkOutput("busyA2 writeback no bypass", busyA2, 1'b1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("release busyVec1[7]", busyVec1[7], 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7); tick();
    applyStimulus(1, 7, 32'h7, 0, 0, 0, 0, 1, 7); tick();
    checkOutput("rsv+wr same busy", busyVec1[7], 1'b1);
    applyStimulus(1, 7, 32'h8, 0, 0, 0, 0, 1, 8); tick();
    checkOutput("rsv+wr diff busy", busyVec1[8:7], 2'b10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    checkOutput("zero reg rsv ignored", busyVec2[0], 1'b0);

    // hold while idle
    applyStimulus(1, 3, 32'h3333_3333, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 0); tick();
    checkOutput("hold initial A1", rdDataA1, 32'h3333_3333);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 3, 32'(k), 0, 0, 0, 0, 0, 0); tick();
      checkOutput("hold rdDataA1", rdDataA1, 32'h3333_3333);
      checkOutput("hold rdValidA1", rdValidA1, 1'b0);
    end

    // sweep of the wide instance
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      wrEn2 = 1'b1; wrAddr2 = 5'(i); wrData2 = 64'(i) ^ 64'hA5A5_5A5A_0F0F_F0F0;
      tick();
    end
    wrEn2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rdEnA2 = 1'b1; rdAddrA2 = 5'(i); rdEnB2 = 1'b1; rdAddrB2 = 5'(31 - i);
      tick();
      checkOutput("sweep A2", rdDataA2, sweepVal(i));
      checkOutput("sweep B2", rdDataB2, sweepVal(31 - i));
    end
    rdEnA2 = 1'b0; rdEnB2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rsvEn2 = 1'b1; rsvAddr2 = 5'(i);
      tick();
    end
    rsvEn2 = 1'b0;
    checkOutput("sweep busyVec2", busyVec2, 32'hFFFF_FFFE);
    tick();

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
